johnson_decoder_5bit: RTL and testbench
=======================================

JOHNSON_DECODER_5BIT -- requirements
Module: johnson_decoder_5bit

Interface
REQ-001 Parameter SHALL be: ERR_W, 8, width of the error counter (legal 2..16).
REQ-002 Port SHALL be: clk  input  1  single clock, all logic on rising edge.
REQ-003 Port SHALL be: rst  input  1  reset, synchronous, active-high.
REQ-004 Port SHALL be: in_valid  input  1  code sample qualifier.
REQ-005 Port SHALL be: code  input  5  sampled 5-bit Johnson counter state.
REQ-006 Port SHALL be: err_clr  input  1  synchronous clear of err_count.
REQ-007 Port SHALL be: out_valid  output  1  registered copy of in_valid.
REQ-008 Port SHALL be: index  output  4  decoded count 0..9, registered.
REQ-009 Port SHALL be: illegal  output  1  one-cycle pulse, sample was not a legal code.
REQ-010 Port SHALL be: seq_err  output  1  one-cycle pulse, legal code out of sequence while LOCKED.
REQ-011 Port SHALL be: locked  output  1  high in LOCKED state.
REQ-012 Port SHALL be: err_count  output  ERR_W  saturating error count.

Function
REQ-013 Legal codes and their indices SHALL be: 00000=0, 00001=1, 00011=2, 00111=3, 01111=4, 11111=5, 11110=6, 11100=7, 11000=8, 10000=9; all other 22 codes are illegal.
REQ-014 The successor of a legal code c SHALL be {c[3:0], ~c[4]}; 10000 wraps to 00000.
REQ-015 All outputs SHALL be registered, with a latency of 1 cycle from the in_valid/code sample to out_valid/index/illegal/seq_err.
REQ-016 On an illegal sample, index SHALL be 4'hF; when in_valid=0, out_valid=0, illegal=0, seq_err=0, and index, state and prev hold.
REQ-017 The FSM SHALL have the states UNLOCKED, ACQUIRE and LOCKED, and SHALL store prev (the last legal code); only valid samples advance it.
REQ-018 In UNLOCKED: legal -> store prev, go to ACQUIRE; illegal -> pulse illegal, stay.
REQ-019 In ACQUIRE: successor of prev -> LOCKED; equal to prev (hold) -> stay; other legal -> store as prev, stay; illegal -> pulse illegal, go to UNLOCKED.
REQ-020 In LOCKED: successor or hold -> stay; other legal -> pulse seq_err, store prev, go to ACQUIRE; illegal -> pulse illegal, go to UNLOCKED.
REQ-021 prev SHALL be updated on every legal valid sample.
REQ-022 illegal and seq_err SHALL never assert in the same cycle.
REQ-023 err_count SHALL increment by 1 on each illegal or seq_err event and saturate at 2^ERR_W-1 without wrapping.
REQ-024 When err_clr is asserted in the same cycle as an error event, err_clr SHALL win and err_count SHALL become 0.

Reset
REQ-025 While rst=1 at a clock edge: the state SHALL be UNLOCKED, prev=00000, out_valid=0, index=0, illegal=0, seq_err=0, locked=0, err_count=0.
REQ-026 rst SHALL take priority over in_valid and err_clr, and reset mid-stream SHALL discard any in-progress acquisition.
REQ-027 The first valid sample after reset SHALL be treated as an UNLOCKED entry, with no seq_err.

Configuration
REQ-028 With JOHNSON_DEC_ERRCNT_EN defined, err_count and err_clr SHALL be implemented as specified in REQ-023 and REQ-024.
REQ-029 Without JOHNSON_DEC_ERRCNT_EN, err_count SHALL be tied to 0, err_clr SHALL be ignored, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then valid codes 00000,00001,00011 on consecutive cycles -> index 0,1,2 one cycle later; locked rises the cycle index=1 appears.
REQ-031 Locked run 11000,10000,00000 -> index 8,9,0, no seq_err (wrap).
REQ-032 Locked at 00111, inject 11100 -> seq_err pulse, index=7, locked=0, err_count=1; then 11000 -> locked=1.
REQ-033 Inject illegal 01010 while locked -> illegal pulse, index=F, locked=0; the next legal code enters ACQUIRE.
REQ-034 With ERR_W=2, apply 5 illegal samples -> err_count 1,2,3,3,3; err_clr coincident with a 6th illegal sample -> err_count=0.
REQ-035 Locked, hold in_valid=0 for 3 cycles, then the same code as prev -> outputs frozen, still locked, no error; assert rst mid-run -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/johnson_decoder_5bit.sv
// Decodes a sampled 5-bit Johnson counter state to a 0..9 index and tracks sequence lock.
// Optional saturating error counter enabled by defining JOHNSON_DEC_ERRCNT_EN.
module johnson_decoder_5bit #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [4:0]       code,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [3:0]       index,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] prev_q, prev_d;
    logic [3:0] index_q, index_d;
    logic       out_valid_q, out_valid_d;
    logic       illegal_q, illegal_d;
    logic       seq_err_q, seq_err_d;

    logic       code_legal;
    logic [3:0] code_idx;
    logic [4:0] succ;

    always_comb begin
        code_legal = 1'b1;
        code_idx   = 4'hF;
        unique case (code)
            5'b00000: code_idx = 4'd0;
            5'b00001: code_idx = 4'd1;
            5'b00011: code_idx = 4'd2;
            5'b00111: code_idx = 4'd3;
            5'b01111: code_idx = 4'd4;
            5'b11111: code_idx = 4'd5;
            5'b11110: code_idx = 4'd6;
            5'b11100: code_idx = 4'd7;
            5'b11000: code_idx = 4'd8;
            5'b10000: code_idx = 4'd9;
            default:  code_legal = 1'b0;
        endcase
    end

    // Shifting in the inverted MSB walks the ten-state Johnson ring, 10000 -> 00000.
    assign succ = {prev_q[3:0], ~prev_q[4]};

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        index_d     = index_q;
        out_valid_d = in_valid;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
        if (in_valid) begin
            index_d = code_legal ? code_idx : 4'hF;
            if (code_legal) begin
                prev_d = code;
            end
            case (state_q)
                UNLOCKED: begin
                    if (code_legal) begin
                        state_d = ACQUIRE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (!code_legal) begin
                        illegal_d = 1'b1;
                        state_d   = UNLOCKED;
                    end else if (code == succ) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!code_legal) begin
                        illegal_d = 1'b1;
                        state_d   = UNLOCKED;
                    end else if (code != succ && code != prev_q) begin
                        seq_err_d = 1'b1;
                        state_d   = ACQUIRE;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            prev_q      <= 5'b00000;
            index_q     <= 4'd0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            index_q     <= index_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign index     = index_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign locked    = (state_q == LOCKED);

`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Clear beats a coincident error; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if ((illegal_d || seq_err_d) && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder_5bit.sv
// Directed-vector scoreboard bench for johnson_decoder_5bit (ERR_W=2 to reach saturation quickly).
module tb_johnson_decoder_5bit;

    localparam int ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [4:0]       code;
    logic             err_clr;
    logic             out_valid;
    logic [3:0]       index;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_count;

    johnson_decoder_5bit #(.ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .code      (code),
        .err_clr   (err_clr),
        .out_valid (out_valid),
        .index     (index),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic             ov;
        logic [3:0]       idx;
        logic             ill;
        logic             seq;
        logic             lk;
        logic [ERR_W-1:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   step_n = 0;
    bit   done   = 1'b0;

    task automatic step(input logic r, input logic v, input logic [4:0] c, input logic clr,
                        input logic ov, input logic [3:0] idx, input logic ill,
                        input logic seq, input logic lk, input int err);
        exp_t e;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        code     = c;
        err_clr  = clr;
        step_n++;
        e.id  = step_n;
        e.ov  = ov;
        e.idx = idx;
        e.ill = ill;
        e.seq = seq;
        e.lk  = lk;
`ifdef JOHNSON_DEC_ERRCNT_EN
        e.err = ERR_W'(err);
`else
        e.err = ERR_W'(0 * err);
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: every output cycle is checked against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (out_valid !== e.ov || index !== e.idx || illegal !== e.ill ||
                    seq_err !== e.seq || locked !== e.lk || err_count !== e.err) begin
                    fails++;
                    $display("FAIL step%0d: got ov=%b idx=%h ill=%b seq=%b lk=%b err=%0d, want ov=%b idx=%h ill=%b seq=%b lk=%b err=%0d",
                             e.id, out_valid, index, illegal, seq_err, locked, err_count,
                             e.ov, e.idx, e.ill, e.seq, e.lk, e.err);
                end
                tests++;
                if (illegal === 1'b1 && seq_err === 1'b1) begin
                    fails++;
                    $display("FAIL excl step%0d: illegal=%b seq_err=%b, want not both", e.id, illegal, seq_err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; code = 5'b0; err_clr = 1'b0;
        //    rst  v   code      clr  ov idx   ill seq lk err
        step(1, 0, 5'b00000, 0, 0, 4'h0, 0, 0, 0, 0);
        step(1, 1, 5'b01010, 1, 0, 4'h0, 0, 0, 0, 0);
        // acquire and lock
        step(0, 1, 5'b00000, 0, 1, 4'h0, 0, 0, 0, 0);
        step(0, 1, 5'b00001, 0, 1, 4'h1, 0, 0, 1, 0);
        step(0, 1, 5'b00011, 0, 1, 4'h2, 0, 0, 1, 0);
        step(0, 1, 5'b00111, 0, 1, 4'h3, 0, 0, 1, 0);
        // out-of-sequence jump, then relock and wrap
        step(0, 1, 5'b11100, 0, 1, 4'h7, 0, 1, 0, 1);
        step(0, 1, 5'b11000, 0, 1, 4'h8, 0, 0, 1, 1);
        step(0, 1, 5'b10000, 0, 1, 4'h9, 0, 0, 1, 1);
        step(0, 1, 5'b00000, 0, 1, 4'h0, 0, 0, 1, 1);
        // idle cycles freeze state, then a hold sample
        step(0, 0, 5'b10101, 0, 0, 4'h0, 0, 0, 1, 1);
        step(0, 0, 5'b11111, 0, 0, 4'h0, 0, 0, 1, 1);
        step(0, 0, 5'b00011, 0, 0, 4'h0, 0, 0, 1, 1);
        step(0, 1, 5'b00000, 0, 1, 4'h0, 0, 0, 1, 1);
        // illegal while locked, reacquire via ACQUIRE paths
        step(0, 1, 5'b01010, 0, 1, 4'hF, 1, 0, 0, 2);
        step(0, 1, 5'b00011, 0, 1, 4'h2, 0, 0, 0, 2);
        step(0, 1, 5'b11110, 0, 1, 4'h6, 0, 0, 0, 2);
        step(0, 1, 5'b11110, 0, 1, 4'h6, 0, 0, 0, 2);
        step(0, 1, 5'b11100, 0, 1, 4'h7, 0, 0, 1, 2);
        step(0, 1, 5'b10000, 0, 1, 4'h9, 0, 1, 0, 3);
        step(0, 1, 5'b00101, 0, 1, 4'hF, 1, 0, 0, 3);
        // saturation, clear beating an error, recount
        step(0, 1, 5'b11011, 0, 1, 4'hF, 1, 0, 0, 3);
        step(0, 1, 5'b01000, 0, 1, 4'hF, 1, 0, 0, 3);
        step(0, 1, 5'b10101, 0, 1, 4'hF, 1, 0, 0, 3);
        step(0, 1, 5'b00100, 1, 1, 4'hF, 1, 0, 0, 0);
        step(0, 1, 5'b01001, 0, 1, 4'hF, 1, 0, 0, 1);
        step(0, 1, 5'b10001, 0, 1, 4'hF, 1, 0, 0, 2);
        step(0, 1, 5'b00010, 0, 1, 4'hF, 1, 0, 0, 3);
        step(0, 1, 5'b01100, 0, 1, 4'hF, 1, 0, 0, 3);
        step(0, 0, 5'b00000, 1, 0, 4'hF, 0, 0, 0, 0);
        // lock, seq error, relock, then reset mid-run
        step(0, 1, 5'b00000, 0, 1, 4'h0, 0, 0, 0, 0);
        step(0, 1, 5'b00001, 0, 1, 4'h1, 0, 0, 1, 0);
        step(0, 1, 5'b01111, 0, 1, 4'h4, 0, 1, 0, 1);
        step(0, 1, 5'b11111, 0, 1, 4'h5, 0, 0, 1, 1);
        step(1, 1, 5'b11110, 1, 0, 4'h0, 0, 0, 0, 0);
        step(0, 1, 5'b11110, 0, 1, 4'h6, 0, 0, 0, 0);
        step(0, 1, 5'b11100, 0, 1, 4'h7, 0, 0, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        done = 1'b1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
